vic_bus_sched: RTL and testbench
================================

Name: vic_bus_sched

Overview:
- Cycle scheduler for the shared C64 address/data bus and DRAM strobes.
- Runs off the 4x dot clock and divides it into 32 ticks per CPU phi cycle.
- Generates phi, RAS/CAS/mux timing, BA/AEC bus-steal handshake and bus-drive enables (vic_write_ab, vic_write_db, ls245_data_dir).
- Sits between the clock generator and the vicii core's pin drivers, replacing ad-hoc strobe logic with one sequenced owner.

Parameters:
- BA_LEAD, 3, number of full phi cycles BA is low before AEC is held low in phi2.
- RAS_TICK, 5, tick within each 16-tick half at which RAS falls.
- MUX_TICK, 7, tick within each half at which mux switches to column address.
- CAS_TICK, 8, tick within each half at which CAS falls.
- DB_TICK, 2, tick within phi2 half at which a register-read drive of the data bus begins.

Ports:
- clk_dot4x  input  1  4x dot clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- steal_req  input  1  core requests the bus for the coming cycles (badline/sprite DMA); level, held while needed.
- ce  input  1  chip enable, active low.
- rw  input  1  CPU read/write (1=read).
- stat_clr  input  1  clears steal_count (optional feature).
- phase  output  5  tick counter 0..31; 0..15 = phi1 (VIC half), 16..31 = phi2 (CPU half).
- clk_phi  output  1  phase[4].
- ras  output  1  row strobe, active low.
- cas  output  1  column strobe, active low.
- mux  output  1  1 = column address on ado.
- ba  output  1  bus available, active low = steal pending/active.
- aec  output  1  1 = CPU owns address bus.
- vic_write_ab  output  1  VIC drives address bus; always equals ~aec.
- vic_write_db  output  1  VIC drives data bus (register read by CPU).
- ls245_data_dir  output  1  equals vic_write_db.
- steal_count  output  16  count of stolen phi2 halves.

Behaviour:
- All outputs are registered.
- phase:
  - Increments every clk_dot4x and wraps 31->0.
  - Reset: phase=0, clk_phi=0.
- Strobes: with h = phase[3:0], in both halves:
  - ras = 0 when h >= RAS_TICK, else 1.
  - mux = 1 when h >= MUX_TICK, else 0.
  - cas = 0 when h >= CAS_TICK, else 1.
  - Reset: ras=1, cas=1, mux=0.
  - Strobes rise together on the half boundary, i.e. the cycle where the registered phase becomes 0 or 16.
- Steal FSM: states IDLE, BA_WAIT, STEAL; counter lead_cnt is 2 bits.
  - Transitions are evaluated only when the next phase = 0, i.e. on the same edge phase becomes 0.
  - IDLE: if steal_req=1, go to BA_WAIT, set ba=0, lead_cnt=0.
  - BA_WAIT:
    - If steal_req=0, go to IDLE and set ba=1.
    - Else if lead_cnt = BA_LEAD-1, go to STEAL.
    - Else increment lead_cnt.
  - STEAL:
    - If steal_req=0, go to IDLE and set ba=1.
    - Else stay.
  - Reset: state=IDLE, ba=1.
- aec:
  - 0 for phase 0..15.
  - For phase 16..31: 1 unless state=STEAL, in which case 0.
  - Reset: aec=0, vic_write_ab=1.
- vic_write_db:
  - 1 when phase is in 16+DB_TICK..31, ce=0, rw=1 and aec=1; else 0.
  - ce/rw are sampled each tick; deassertion mid-window drops vic_write_db on the next edge.
  - Reset: 0.
  - Never 1 while vic_write_ab=1.
- Simultaneous events:
  - A steal_req rise and fall between two phase-0 points is ignored.
  - Re-request on the same phase-0 edge that exits STEAL is not possible: exit requires steal_req=0.
- Reset mid-cycle: the next edge forces all of the reset values above, and the FSM abandons any steal.

Optional Feature:
- Macro: VIC_BUS_SCHED_STATS_EN.
- Defined:
  - steal_count increments by 1 at each phase=16 edge while state=STEAL.
  - Saturates at 16'hFFFF.
  - stat_clr=1 clears it to 0, and clear has priority over increment.
  - Reset: 0.
- Undefined: steal_count is tied to 16'h0000 and stat_clr is ignored.

Test Plan:
- Release rst at arbitrary time -> phase counts 0..31; clk_phi=0 for ticks 0-15 and 1 for 16-31; ras falls at ticks 5/21, mux rises at 7/23, cas falls at 8/24; all three return high/low at 0/16.
- Assert steal_req at phase 10 and hold -> ba=0 from the next phase 0; aec=1 in phi2 of the first 3 cycles; aec=0 in phi2 of the 4th cycle onward; vic_write_ab=1 throughout the steal.
- Drop steal_req during BA_WAIT (cycle 2) -> ba returns to 1 at the next phase 0; aec never held low in phi2.
- ce=0, rw=1 during phi2 in IDLE -> vic_write_db and ls245_data_dir = 1 for phase 18..31, 0 elsewhere; same stimulus in STEAL -> stays 0.
- Assert rst at phase 20 during STEAL -> next edge: phase=0, ba=1, aec=0, ras=cas=1, state IDLE.
- With VIC_BUS_SCHED_STATS_EN: 5 stolen cycles -> steal_count=5; stat_clr pulse at the same edge as an increment -> 0.

Source files
------------

// File: rtl/vic_bus_sched.sv
// Bus cycle scheduler: phi/DRAM strobe sequencing plus the BA/AEC steal handshake.
// Optional steal statistics counter enabled by defining VIC_BUS_SCHED_STATS_EN.
module vic_bus_sched #(
  parameter int BA_LEAD  = 3,
  parameter int RAS_TICK = 5,
  parameter int MUX_TICK = 7,
  parameter int CAS_TICK = 8,
  parameter int DB_TICK  = 2
) (
  input  logic        clk_dot4x,
  input  logic        rst,
  input  logic        steal_req,
  input  logic        ce,
  input  logic        rw,
  input  logic        stat_clr,
  output logic [4:0]  phase,
  output logic        clk_phi,
  output logic        ras,
  output logic        cas,
  output logic        mux,
  output logic        ba,
  output logic        aec,
  output logic        vic_write_ab,
  output logic        vic_write_db,
  output logic        ls245_data_dir,
  output logic [15:0] steal_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BA_WAIT = 2'd1,
    STEAL   = 2'd2
  } state_t;

  state_t      state_r;
  logic [1:0]  lead_cnt_r;
  logic [4:0]  phase_r;
  logic [4:0]  phase_next_s;
  logic [3:0]  h_next_s;
  logic        clk_phi_r, ras_r, cas_r, mux_r, ba_r, aec_r, wab_r, wdb_r;
  logic        aec_next_s, wdb_next_s;

  // Next-tick view; state only changes on the phase-0 edge, where aec is 0 anyway
  always_comb begin
    phase_next_s = phase_r + 5'd1;
    h_next_s     = phase_next_s[3:0];
    if (phase_next_s[4] && (state_r != STEAL)) begin
      aec_next_s = 1'b1;
    end else begin
      aec_next_s = 1'b0;
    end
    if ((phase_next_s >= 5'(16 + DB_TICK)) && !ce && rw && aec_next_s) begin
      wdb_next_s = 1'b1;
    end else begin
      wdb_next_s = 1'b0;
    end
  end

  // Tick counter, DRAM strobes and bus-drive enables
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      phase_r   <= 5'd0;
      clk_phi_r <= 1'b0;
      ras_r     <= 1'b1;
      cas_r     <= 1'b1;
      mux_r     <= 1'b0;
      aec_r     <= 1'b0;
      wab_r     <= 1'b1;
      wdb_r     <= 1'b0;
    end else begin
      phase_r   <= phase_next_s;
      clk_phi_r <= phase_next_s[4];
      ras_r     <= (h_next_s >= 4'(RAS_TICK)) ? 1'b0 : 1'b1;
      cas_r     <= (h_next_s >= 4'(CAS_TICK)) ? 1'b0 : 1'b1;
      mux_r     <= (h_next_s >= 4'(MUX_TICK)) ? 1'b1 : 1'b0;
      aec_r     <= aec_next_s;
      wab_r     <= ~aec_next_s;
      wdb_r     <= wdb_next_s;
    end
  end

  // Steal handshake, advanced only on the edge that starts a new phi cycle
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      state_r    <= IDLE;
      lead_cnt_r <= 2'd0;
      ba_r       <= 1'b1;
    end else if (phase_next_s == 5'd0) begin
      case (state_r)
        IDLE: begin
          if (steal_req) begin
            state_r    <= BA_WAIT;
            ba_r       <= 1'b0;
            lead_cnt_r <= 2'd0;
          end else begin
            state_r    <= IDLE;
            ba_r       <= 1'b1;
          end
        end
        BA_WAIT: begin
          if (!steal_req) begin
            state_r <= IDLE;
            ba_r    <= 1'b1;
          end else if (lead_cnt_r == 2'(BA_LEAD - 1)) begin
            state_r <= STEAL;
          end else begin
            lead_cnt_r <= lead_cnt_r + 2'd1;
          end
        end
        STEAL: begin
          if (!steal_req) begin
            state_r <= IDLE;
            ba_r    <= 1'b1;
          end else begin
            state_r <= STEAL;
          end
        end
        default: begin
          state_r    <= IDLE;
          ba_r       <= 1'b1;
          lead_cnt_r <= 2'd0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

`ifdef VIC_BUS_SCHED_STATS_EN
  logic [15:0] steal_count_r;

  // Saturating count of phi2 halves taken from the CPU; clear wins over increment
  always_ff @(posedge clk_dot4x) begin
    if (rst) begin
      steal_count_r <= 16'h0000;
    end else if (stat_clr) begin
      steal_count_r <= 16'h0000;
    end else if ((phase_next_s == 5'd16) && (state_r == STEAL) &&
                 (steal_count_r != 16'hFFFF)) begin
      steal_count_r <= steal_count_r + 16'h0001;
    end else begin
      steal_count_r <= steal_count_r;
    end
  end

  assign steal_count = steal_count_r;
`else
  logic unused_stat_clr_s;
  assign unused_stat_clr_s = stat_clr;
  assign steal_count       = 16'h0000;
`endif

  assign phase          = phase_r;
  assign clk_phi        = clk_phi_r;
  assign ras            = ras_r;
  assign cas            = cas_r;
  assign mux            = mux_r;
  assign ba             = ba_r;
  assign aec            = aec_r;
  assign vic_write_ab   = wab_r;
  assign vic_write_db   = wdb_r;
  assign ls245_data_dir = wdb_r;

endmodule

// File: tb/tb_vic_bus_sched.sv
// Self-checking bench for vic_bus_sched: directed phases with random inputs,
// checked every tick against a cycle-level reference model.
module tb_vic_bus_sched;

  localparam int BA_LEAD  = 3;
  localparam int RAS_TICK = 5;
  localparam int MUX_TICK = 7;
  localparam int CAS_TICK = 8;
  localparam int DB_TICK  = 2;

  logic        clk = 1'b0;
  logic        rst, steal_req, ce, rw, stat_clr;
  logic [4:0]  phase;
  logic        clk_phi, ras, cas, mux, ba, aec, vic_write_ab, vic_write_db, ls245_data_dir;
  logic [15:0] steal_count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  // Reference model: phase number, consecutive phase-0 samples of steal_req
  int phase_m  = 0;
  int consec   = 0;
  int cnt_m    = 0;
  bit wdb_m    = 1'b0;

  vic_bus_sched dut (
    .clk_dot4x(clk), .rst(rst), .steal_req(steal_req), .ce(ce), .rw(rw),
    .stat_clr(stat_clr), .phase(phase), .clk_phi(clk_phi), .ras(ras), .cas(cas),
    .mux(mux), .ba(ba), .aec(aec), .vic_write_ab(vic_write_ab),
    .vic_write_db(vic_write_db), .ls245_data_dir(ls245_data_dir),
    .steal_count(steal_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h (model phase %0d)", tag, obs, exp, phase_m);
    end
  endtask

  task automatic check_all();
    int  h;
    bit  aec_e;
    h     = phase_m % 16;
    aec_e = (phase_m >= 16) && (consec <= BA_LEAD);
    chk("phase",   16'(phase),          16'(phase_m));
    chk("clk_phi", 16'(clk_phi),        16'(phase_m >= 16));
    chk("ras",     16'(ras),            16'(h < RAS_TICK));
    chk("mux",     16'(mux),            16'(h >= MUX_TICK));
    chk("cas",     16'(cas),            16'(h < CAS_TICK));
    chk("ba",      16'(ba),             16'(consec == 0));
    chk("aec",     16'(aec),            16'(aec_e));
    chk("wab",     16'(vic_write_ab),   16'(!aec_e));
    chk("wdb",     16'(vic_write_db),   16'(wdb_m));
    chk("ls245",   16'(ls245_data_dir), 16'(wdb_m));
`ifdef VIC_BUS_SCHED_STATS_EN
    chk("steal_count", steal_count, 16'(cnt_m));
`else
    chk("steal_count", steal_count, 16'h0000);
`endif
  endtask

  task automatic step(input logic r, input logic sr, input logic c, input logic w, input logic sc);
    bit aec_e;
    rst = r; steal_req = sr; ce = c; rw = w; stat_clr = sc;
    @(posedge clk);
    if (r) begin
      phase_m = 0; consec = 0; cnt_m = 0; wdb_m = 1'b0;
    end else begin
      phase_m = (phase_m + 1) % 32;
      if (phase_m == 0) consec = sr ? ((consec < 7) ? consec + 1 : 7) : 0;
      aec_e = (phase_m >= 16) && (consec <= BA_LEAD);
      wdb_m = (phase_m >= 16 + DB_TICK) && !c && w && aec_e;
      if (sc) cnt_m = 0;
      else if (phase_m == 16 && consec > BA_LEAD && cnt_m < 65535) cnt_m++;
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst = 1'b1; steal_req = 1'b0; ce = 1'b1; rw = 1'b1; stat_clr = 1'b0;

    // Reset, then release at an arbitrary point
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    // Idle phi cycles with random CPU accesses
    for (int i = 0; i < 64; i++)
      step(1'b0, 1'b0, 1'($urandom % 2), 1'($urandom % 2), 1'b0);

    // Request the bus at phase 10 and hold through several stolen cycles
    for (int i = 0; i < 40 && phase_m != 9; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 32 * 7; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Drop the request while BA is still leading
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Slowly toggling random requests, random CPU accesses and clears
    begin
      logic sr;
      sr = 1'b0;
      for (int i = 0; i < 1200; i++) begin
        if ($urandom % 24 == 0) sr = ~sr;
        step(1'b0, sr, 1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 97 == 0));
      end
    end

    // Clear first, then count stolen cycles, with one clear landing on an increment edge
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 32 * 10; i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 40 && phase_m != 15; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset in the middle of a steal at phase 20
    for (int i = 0; i < 400 && !(phase_m == 20 && consec > BA_LEAD); i++)
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
